memlibc_memory_bist_step_scheduler: RTL and testbench



---
 rtl/memlibc_memory_bist_step_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_memlibc_memory_bist_step_scheduler.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memlibc_memory_bist_step_scheduler.sv
// Runs the masked memory BIST controllers one at a time, lowest index first, and collects their pass/fail.
// Optional RUN watchdog: define MEMLIBC_BIST_SCHED_TIMEOUT_EN.
module memlibc_memory_bist_step_scheduler #(
  parameter int unsigned NUM_CTRL       = 4,
  parameter int unsigned IDX_W          = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                bist_clk,
  input  logic                bist_rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [NUM_CTRL-1:0] ctrl_mask,
  input  logic [NUM_CTRL-1:0] ctrl_done,
  input  logic [NUM_CTRL-1:0] ctrl_go,
  output logic [NUM_CTRL-1:0] ctrl_start,
  output logic [IDX_W-1:0]    cur_idx,
  output logic                busy,
  output logic                all_done,
  output logic                all_go,
  output logic [NUM_CTRL-1:0] fail_vec,
  output logic                timeout_flag
);

  localparam int unsigned WDOG_W   = 20;
  localparam int unsigned IDX_REQ  = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1;

  if (NUM_CTRL < 1 || NUM_CTRL > 16 || IDX_W != IDX_REQ ||
      TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (1 << WDOG_W)) begin : g_bad_param
    $error("memlibc_memory_bist_step_scheduler: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_RUN,
    S_GAP,
    S_COMPLETE
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_CTRL-1:0] mask_q, mask_d;
  logic [NUM_CTRL-1:0] ctrl_start_q, ctrl_start_d;
  logic [IDX_W-1:0]    cur_idx_q, cur_idx_d;
  logic                busy_q, busy_d;
  logic                all_done_q, all_done_d;
  logic                all_go_q, all_go_d;
  logic [NUM_CTRL-1:0] fail_vec_q, fail_vec_d;
  logic                timeout_q, timeout_d;
`ifdef MEMLIBC_BIST_SCHED_TIMEOUT_EN
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
`endif

  logic                sel_found;
  logic [IDX_W-1:0]    sel_idx;

  // Lowest enabled controller at or above the current index.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = NUM_CTRL - 1; i >= 0; i--) begin
      if (mask_q[i] && (i >= int'(cur_idx_q))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    ctrl_start_d = ctrl_start_q;
    cur_idx_d    = cur_idx_q;
    busy_d       = busy_q;
    all_done_d   = all_done_q;
    all_go_d     = all_go_q;
    fail_vec_d   = fail_vec_q;
    timeout_d    = timeout_q;
`ifdef MEMLIBC_BIST_SCHED_TIMEOUT_EN
    wdog_d       = wdog_q;
`endif

    unique case (state_q)
      S_IDLE, S_COMPLETE: begin
        if (start && !abort) begin
          mask_d     = ctrl_mask;
          fail_vec_d = '0;
          timeout_d  = 1'b0;
          all_done_d = 1'b0;
          all_go_d   = 1'b0;
          cur_idx_d  = '0;
          busy_d     = 1'b1;
          state_d    = S_SELECT;
        end
      end
      S_SELECT: begin
        if (sel_found) begin
          cur_idx_d    = sel_idx;
          ctrl_start_d = NUM_CTRL'(1) << sel_idx;
          state_d      = S_RUN;
`ifdef MEMLIBC_BIST_SCHED_TIMEOUT_EN
          wdog_d       = '0;
`endif
        end else begin
          busy_d     = 1'b0;
          all_done_d = 1'b1;
          all_go_d   = ~|fail_vec_q;
          state_d    = S_COMPLETE;
        end
      end
      S_RUN: begin
        if (ctrl_done[cur_idx_q]) begin
          fail_vec_d[cur_idx_q] = ~ctrl_go[cur_idx_q];
          ctrl_start_d          = '0;
          state_d               = S_GAP;
        end
`ifdef MEMLIBC_BIST_SCHED_TIMEOUT_EN
        else if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
          fail_vec_d[cur_idx_q] = 1'b1;
          timeout_d             = 1'b1;
          ctrl_start_d          = '0;
          state_d               = S_GAP;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
`endif
      end
      S_GAP: begin
        if (!ctrl_done[cur_idx_q]) begin
          if (cur_idx_q == IDX_W'(NUM_CTRL - 1)) begin
            busy_d     = 1'b0;
            all_done_d = 1'b1;
            all_go_d   = ~|fail_vec_q;
            state_d    = S_COMPLETE;
          end else begin
            cur_idx_d = cur_idx_q + IDX_W'(1);
            state_d   = S_SELECT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort outranks start and done; the fail history survives it.
    if (abort && (state_q != S_IDLE)) begin
      state_d      = S_IDLE;
      ctrl_start_d = '0;
      busy_d       = 1'b0;
      all_done_d   = 1'b0;
      all_go_d     = 1'b0;
      cur_idx_d    = cur_idx_q;
      fail_vec_d   = fail_vec_q;
      timeout_d    = timeout_q;
    end
  end

  always_ff @(posedge bist_clk or negedge bist_rst_n) begin
    if (!bist_rst_n) begin
      state_q      <= S_IDLE;
      mask_q       <= '0;
      ctrl_start_q <= '0;
      cur_idx_q    <= '0;
      busy_q       <= 1'b0;
      all_done_q   <= 1'b0;
      all_go_q     <= 1'b0;
      fail_vec_q   <= '0;
      timeout_q    <= 1'b0;
`ifdef MEMLIBC_BIST_SCHED_TIMEOUT_EN
      wdog_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      ctrl_start_q <= ctrl_start_d;
      cur_idx_q    <= cur_idx_d;
      busy_q       <= busy_d;
      all_done_q   <= all_done_d;
      all_go_q     <= all_go_d;
      fail_vec_q   <= fail_vec_d;
      timeout_q    <= timeout_d;
`ifdef MEMLIBC_BIST_SCHED_TIMEOUT_EN
      wdog_q       <= wdog_d;
`endif
    end
  end

  assign ctrl_start = ctrl_start_q;
  assign cur_idx    = cur_idx_q;
  assign busy       = busy_q;
  assign all_done   = all_done_q;
  assign all_go     = all_go_q;
  assign fail_vec   = fail_vec_q;
`ifdef MEMLIBC_BIST_SCHED_TIMEOUT_EN
  assign timeout_flag = timeout_q;
`else
  assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_memlibc_memory_bist_step_scheduler.sv
// Scoreboard bench for the BIST step scheduler: modelled controllers, expected start order and pass results.
module tb_memlibc_memory_bist_step_scheduler;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned TO = 8;
`ifdef MEMLIBC_BIST_SCHED_TIMEOUT_EN
  localparam int BASIC_DLY = 5;
`else
  localparam int BASIC_DLY = 10;
`endif

  logic          bist_clk = 1'b0;
  logic          bist_rst_n, start, abort;
  logic [N-1:0]  ctrl_mask, ctrl_done, ctrl_go;
  logic [N-1:0]  ctrl_start, fail_vec;
  logic [IW-1:0] cur_idx;
  logic          busy, all_done, all_go, timeout_flag;

  memlibc_memory_bist_step_scheduler #(.NUM_CTRL(N), .IDX_W(IW), .TIMEOUT_CYCLES(TO)) dut (
    .bist_clk(bist_clk), .bist_rst_n(bist_rst_n), .start(start), .abort(abort),
    .ctrl_mask(ctrl_mask), .ctrl_done(ctrl_done), .ctrl_go(ctrl_go),
    .ctrl_start(ctrl_start), .cur_idx(cur_idx), .busy(busy), .all_done(all_done),
    .all_go(all_go), .fail_vec(fail_vec), .timeout_flag(timeout_flag)
  );

  always #5 bist_clk = ~bist_clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [N-1:0] fail;
    logic         go;
    logic         to;
  } res_t;

  int   exp_start_q[$];
  res_t exp_res_q[$];

  int   dly     [N];
  logic go_plan [N];
  bit   hang    [N];
  bit   noise_en = 1'b0;

  // Reference: enabled controllers start in ascending order; each failure comes from go=0 or a watchdog hit.
  task automatic push_expect(input logic [N-1:0] m, input bit with_res);
    res_t r;
    r.fail = '0;
    r.to   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (m[i]) begin
        exp_start_q.push_back(i);
        if (hang[i]) begin
          r.fail[i] = 1'b1;
          r.to      = 1'b1;
        end else begin
          r.fail[i] = ~go_plan[i];
        end
      end
    end
    r.go = (r.fail == '0);
    if (with_res) exp_res_q.push_back(r);
  endtask

  // Controller model: done/go after dly cycles of start, held until start drops plus a random tail.
  initial begin
    int ph, ridx, cnt, hold;
    ph = 0; ridx = 0; cnt = 0; hold = 0;
    ctrl_done = '0;
    ctrl_go   = '0;
    forever begin
      @(negedge bist_clk);
      if (!bist_rst_n) begin
        ph = 0;
        ctrl_done = '0;
        ctrl_go   = '0;
        continue;
      end
      case (ph)
        0: if (ctrl_start != '0) begin
             for (int i = 0; i < N; i++) if (ctrl_start[i]) ridx = i;
             cnt = dly[ridx];
             ctrl_done[ridx] = 1'b0;
             ph = 1;
           end
        1: if (!ctrl_start[ridx]) ph = 0;
           else if (!hang[ridx]) begin
             if (cnt == 0) begin
               ctrl_done[ridx] = 1'b1;
               ctrl_go[ridx]   = go_plan[ridx];
               hold = int'($urandom_range(0, 2));
               ph = 2;
             end else cnt--;
           end
        default: if (!ctrl_start[ridx]) begin
             if (hold == 0) begin
               ctrl_done[ridx] = 1'b0;
               ctrl_go[ridx]   = 1'($urandom);
               ph = 0;
             end else hold--;
           end
      endcase
      for (int i = 0; i < N; i++) begin
        if (!(ph != 0 && i == ridx)) begin
          if (noise_en && !ctrl_start[i]) begin
            ctrl_done[i] = 1'($urandom);
            ctrl_go[i]   = 1'($urandom);
          end else begin
            ctrl_done[i] = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: every new start and every pass completion is matched against the scoreboard.
  initial begin
    logic [N-1:0] pcs, e;
    logic         pdone;
    int           idx;
    res_t         r;
    pcs = '0;
    pdone = 1'b0;
    forever begin
      @(negedge bist_clk);
      if (ctrl_start != pcs && ctrl_start != '0) begin
        check("start_onehot", 32'($onehot(ctrl_start)), 32'd1);
        if (pcs != '0) check("start_handover_gap", 32'(pcs), 32'd0);
        if (exp_start_q.size() == 0) check("start_unexpected", 32'(ctrl_start), 32'd0);
        else begin
          idx = exp_start_q.pop_front();
          e = '0;
          e[idx] = 1'b1;
          check("start_order", 32'(ctrl_start), 32'(e));
        end
      end
      if (all_done && !pdone) begin
        if (exp_res_q.size() == 0) check("done_unexpected", 32'(all_done), 32'd0);
        else begin
          r = exp_res_q.pop_front();
          check("pass_fail_vec", 32'(fail_vec), 32'(r.fail));
          check("pass_all_go", 32'(all_go), 32'(r.go));
          check("pass_timeout_flag", 32'(timeout_flag), 32'(r.to));
          check("pass_busy_low", 32'(busy), 32'd0);
        end
      end
      pcs = ctrl_start;
      pdone = all_done;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge bist_clk);
  endtask

  task automatic pulse_start(input logic [N-1:0] m);
    ctrl_mask = m;
    start = 1'b1;
    @(negedge bist_clk);
    start = 1'b0;
    ctrl_mask = N'($urandom);
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!all_done && k < 3000) begin
      @(negedge bist_clk);
      k++;
    end
    check(name, 32'(all_done), 32'd1);
    tick(1);
    check("scoreboard_drained", 32'(exp_start_q.size() + exp_res_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl_start"}, 32'(ctrl_start), 32'd0);
    check({tag, "_cur_idx"}, 32'(cur_idx), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_all_done"}, 32'(all_done), 32'd0);
    check({tag, "_all_go"}, 32'(all_go), 32'd0);
    check({tag, "_fail_vec"}, 32'(fail_vec), 32'd0);
    check({tag, "_timeout_flag"}, 32'(timeout_flag), 32'd0);
  endtask

  task automatic plan_all(input int d, input logic g);
    for (int i = 0; i < N; i++) begin
      dly[i] = d;
      go_plan[i] = g;
      hang[i] = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    int k;
    bit seen;
    logic [N-1:0] m;
    bist_rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    ctrl_mask = '0;
    plan_all(2, 1'b1);
    tick(2);
    check_all_zero("reset");
    bist_rst_n = 1'b1;
    tick(2);

    // All four controllers, all passing
    plan_all(BASIC_DLY, 1'b1);
    push_expect(4'b1111, 1'b1);
    pulse_start(4'b1111);
    wait_done("basic_done");
    check("basic_fail_vec", 32'(fail_vec), 32'd0);
    check("basic_all_go", 32'(all_go), 32'd1);
    check("basic_cur_idx", 32'(cur_idx), 32'd3);

    // Sparse mask with the top controller failing
    plan_all(3, 1'b1);
    go_plan[3] = 1'b0;
    push_expect(4'b1010, 1'b1);
    pulse_start(4'b1010);
    wait_done("masked_done");
    check("masked_fail_vec", 32'(fail_vec), 32'h8);
    check("masked_all_go", 32'(all_go), 32'd0);
    check("masked_cur_idx", 32'(cur_idx), 32'd3);

    // Empty mask completes two edges after start
    push_expect(4'b0000, 1'b1);
    pulse_start(4'b0000);
    check("empty_busy_k1", 32'(busy), 32'd1);
    check("empty_done_k1", 32'(all_done), 32'd0);
    tick(1);
    check("empty_done_k2", 32'(all_done), 32'd1);
    check("empty_go_k2", 32'(all_go), 32'd1);
    check("empty_fail_cleared", 32'(fail_vec), 32'd0);
    tick(1);

    // Randomised passes with noise on idle controllers and ignored restarts
    noise_en = 1'b1;
    for (int t = 0; t < 25; t++) begin
      m = N'($urandom);
      for (int i = 0; i < N; i++) begin
        dly[i] = int'($urandom_range(0, 4));
        go_plan[i] = ($urandom_range(0, 3) != 0);
        hang[i] = 1'b0;
      end
      push_expect(m, 1'b1);
      pulse_start(m);
      tick(int'($urandom_range(1, 6)));
      if (busy) begin
        start = 1'b1;
        ctrl_mask = N'($urandom);
        tick(1);
        start = 1'b0;
      end
      wait_done("random_done");
    end

    // Abort on controller 2 in the same cycle as its done
    noise_en = 1'b0;
    plan_all(1, 1'b1);
    dly[2] = 3;
    go_plan[2] = 1'b0;
    for (int i = 0; i < 3; i++) exp_start_q.push_back(i);
    pulse_start(4'b1111);
    k = 0;
    while (ctrl_done[2] !== 1'b1 && k < 500) begin
      @(negedge bist_clk);
      #1;
      k++;
    end
    check("abort_reach_ctrl2", 32'(ctrl_done[2]), 32'd1);
    abort = 1'b1;
    @(negedge bist_clk);
    check("abort_ctrl_start", 32'(ctrl_start), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_all_done", 32'(all_done), 32'd0);
    check("abort_fail_vec", 32'(fail_vec), 32'd0);
    start = 1'b1;
    ctrl_mask = 4'b1111;
    tick(1);
    start = 1'b0;
    tick(1);
    check("abort_blocks_start", 32'(busy), 32'd0);
    abort = 1'b0;
    tick(3);
    check("abort_drained", 32'(exp_start_q.size()), 32'd0);

`ifdef MEMLIBC_BIST_SCHED_TIMEOUT_EN
    // Controller 0 never answers; the watchdog fails it after TO run cycles
    plan_all(2, 1'b1);
    hang[0] = 1'b1;
    push_expect(4'b0011, 1'b1);
    pulse_start(4'b0011);
    k = 0;
    while (!ctrl_start[0] && k < 20) begin tick(1); k++; end
    k = 0;
    while (ctrl_start[0] && k < 100) begin tick(1); k++; end
    check("timeout_run_cycles", 32'(k), 32'(TO));
    wait_done("timeout_done");
    check("timeout_flag_set", 32'(timeout_flag), 32'd1);
    check("timeout_fail_vec", 32'(fail_vec), 32'h1);
`else
    // Without the watchdog a silent controller holds the pass in RUN
    plan_all(2, 1'b1);
    hang[0] = 1'b1;
    exp_start_q.push_back(0);
    pulse_start(4'b0001);
    tick(40);
    check("nowdog_still_running", 32'(ctrl_start), 32'h1);
    check("nowdog_busy", 32'(busy), 32'd1);
    check("nowdog_timeout_flag", 32'(timeout_flag), 32'd0);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("nowdog_abort_busy", 32'(busy), 32'd0);
`endif
    hang[0] = 1'b0;
    tick(2);

    // Reset while waiting in the gap after controller 1
    plan_all(2, 1'b1);
    push_expect(4'b1111, 1'b1);
    pulse_start(4'b1111);
    k = 0;
    seen = 1'b0;
    while (!(seen && ctrl_start == '0 && busy) && k < 500) begin
      if (ctrl_start[1]) seen = 1'b1;
      tick(1);
      k++;
    end
    check("gap_reached", 32'(seen && busy && ctrl_start == '0), 32'd1);
    bist_rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_start_q.delete();
    exp_res_q.delete();
    tick(2);
    bist_rst_n = 1'b1;
    tick(2);
    plan_all(1, 1'b1);
    go_plan[1] = 1'b0;
    push_expect(4'b0111, 1'b1);
    pulse_start(4'b0111);
    wait_done("post_reset_done");
    check("post_reset_fail_vec", 32'(fail_vec), 32'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
